// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - command sequencer driving a fixed-latency integer calculator
//
// Purpose: queues arithmetic commands in a small FIFO, issues each to the
// calculator, samples the result CALC_LAT cycles later and returns it over a
// valid/ready result port. Divide/modulo by zero and illegal opcodes are
// trapped locally and never reach the calculator.
//
// Optional build macro: CALC_CTRL_STATS_EN adds result/error counters.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b          command opcode and operands
//   calc_op, calc_opa, calc_opb   registered drive to the calculator
//   calc_res                      calculator result
//   res_valid/res_ready           result handshake
//   res_data, res_err             result value and trap flag (data is 0 on trap)
//   busy                          FSM active or commands queued
//   stat_cmds, stat_errs          (CALC_CTRL_STATS_EN only) saturating counters
module calc_ctrl #(
  parameter int WIDTH      = 16,
  parameter int CALC_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       calc_op,
  output logic [WIDTH-1:0] calc_opa,
  output logic [WIDTH-1:0] calc_opb,
  input  logic [WIDTH-1:0] calc_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
`ifdef CALC_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_cmds,
  output logic [15:0]      stat_errs
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 + 2 * WIDTH;
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [3:0]    LAT_INIT = 4'(CALC_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  state_t           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [2:0]       calc_op_q, calc_op_d;
  logic [WIDTH-1:0] calc_opa_q, calc_opa_d, calc_opb_q, calc_opb_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;

  logic             push, pop, trap;
  logic [2:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;

  // Full is decided from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign cmd_ready = (count_q != CNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  assign {head_op, head_a, head_b} = fifo_mem[rd_ptr_q];
  assign trap = (head_op > 3'd4) ||
                (((head_op == 3'd3) || (head_op == 3'd4)) && (head_b == '0));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    lat_d       = lat_q;
    calc_op_d   = calc_op_q;
    calc_opa_d  = calc_opa_q;
    calc_opb_d  = calc_opb_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          if (trap) begin
            // calc_* deliberately left alone: the calculator never sees it.
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            calc_op_d  = head_op;
            calc_opa_d = head_a;
            calc_opb_d = head_b;
            lat_d      = LAT_INIT;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          res_data_d  = calc_res;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here means the next pop is one edge later.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      lat_q       <= '0;
      calc_op_q   <= '0;
      calc_opa_q  <= '0;
      calc_opb_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      lat_q       <= lat_d;
      calc_op_q   <= calc_op_d;
      calc_opa_q  <= calc_opa_d;
      calc_opb_q  <= calc_opb_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign calc_op   = calc_op_q;
  assign calc_opa  = calc_opa_q;
  assign calc_opb  = calc_opb_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);

`ifdef CALC_CTRL_STATS_EN
  logic [15:0] stat_cmds_q, stat_cmds_d, stat_errs_q, stat_errs_d;
  logic        res_fire;

  assign res_fire = res_valid_q && res_ready;

  always_comb begin
    stat_cmds_d = stat_cmds_q;
    stat_errs_d = stat_errs_q;
    if (res_fire && (stat_cmds_q != 16'hFFFF)) stat_cmds_d = stat_cmds_q + 16'd1;
    if (res_fire && res_err_q && (stat_errs_q != 16'hFFFF)) stat_errs_d = stat_errs_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cmds_q <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_cmds_q <= stat_cmds_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_cmds = stat_cmds_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - directed self-checking bench for calc_ctrl
module tb_calc_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [2:0]       calc_op;
  logic [WIDTH-1:0] calc_opa, calc_opb;
  logic [WIDTH-1:0] calc_res = '0;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             busy;
`ifdef CALC_CTRL_STATS_EN
  logic [15:0]      stat_cmds, stat_errs;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  calc_ctrl #(.WIDTH(WIDTH), .CALC_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .calc_op   (calc_op),
    .calc_opa  (calc_opa),
    .calc_opb  (calc_opb),
    .calc_res  (calc_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
`ifdef CALC_CTRL_STATS_EN
    ,
    .stat_cmds (stat_cmds),
    .stat_errs (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Calculator model: one register stage, so a result is only correct when
  // sampled at least two edges after calc_* change.
  always @(posedge clk) begin
    case (calc_op)
      3'd0: calc_res <= calc_opa + calc_opb;
      3'd1: calc_res <= calc_opa - calc_opb;
      3'd2: calc_res <= calc_opa * calc_opb;
      3'd3: calc_res <= (calc_opb != 0) ? calc_opa / calc_opb : '0;
      3'd4: calc_res <= (calc_opb != 0) ? calc_opa % calc_opb : '0;
      default: calc_res <= '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int budget = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!cmd_ready) check("send_ready_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_data [5] = '{16'd6, 16'd12, 16'd1, 16'd3, 16'd5};
  logic [WIDTH-1:0] got_data [5];
  logic             got_err  [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int budget;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_calc_op",   calc_op, 0);
    check("rst_calc_opa",  calc_opa, 0);
    check("rst_res_data",  res_data, 0);
    check("rst_res_err",   res_err, 0);
    check("rst_busy",      busy, 0);

    // Single add 5+7, result valid after E3
    send(3'd0, 16'd5, 16'd7);
    check("add_e0_valid", res_valid, 0);
    check("add_e0_busy",  busy, 1);
    tick();
    check("add_e1_op",    calc_op, 0);
    check("add_e1_opa",   calc_opa, 5);
    check("add_e1_opb",   calc_opb, 7);
    check("add_e1_valid", res_valid, 0);
    tick();
    check("add_e2_valid", res_valid, 0);
    tick();
    check("add_e3_valid", res_valid, 1);
    check("add_e3_data",  res_data, 12);
    check("add_e3_err",   res_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("add_hold_data",  res_data, 12);
      check("add_hold_valid", res_valid, 1);
    end
    handshake();
    check("add_after_hs_valid", res_valid, 0);

    // Divide by zero: trapped, valid after E1, calc_* untouched
    send(3'd3, 16'd100, 16'd0);
    check("dz_e0_valid", res_valid, 0);
    tick();
    check("dz_e1_valid", res_valid, 1);
    check("dz_data",     res_data, 0);
    check("dz_err",      res_err, 1);
    check("dz_calc_op",  calc_op, 0);
    check("dz_calc_opa", calc_opa, 5);
    check("dz_calc_opb", calc_opb, 7);
    handshake();

    // Illegal opcode 110
    send(3'd6, 16'd1, 16'd1);
    tick();
    check("ill_valid",    res_valid, 1);
    check("ill_data",     res_data, 0);
    check("ill_err",      res_err, 1);
    check("ill_calc_op",  calc_op, 0);
    check("ill_calc_opa", calc_opa, 5);
    check("ill_calc_opb", calc_opb, 7);
    handshake();

`ifdef CALC_CTRL_STATS_EN
    check("stat_cmds", stat_cmds, 3);
    check("stat_errs", stat_errs, 2);
`endif

    // Back-pressure: five commands with res_ready low
    res_ready = 1'b0;
    send(3'd1, 16'd9, 16'd3);
    send(3'd2, 16'd3, 16'd4);
    send(3'd4, 16'd10, 16'd3);
    send(3'd0, 16'd1, 16'd2);
    check("bp_ready_after4", cmd_ready, 1);
    send(3'd3, 16'd20, 16'd4);
    check("bp_ready_after5", cmd_ready, 0);
    tick();
    tick();
    check("bp_ready_held", cmd_ready, 0);
    check("bp_busy",       busy, 1);
    res_ready = 1'b1;
    k = 0;
    budget = 0;
    while (k < 5 && budget < 100) begin
      if (res_valid) begin
        got_data[k] = res_data;
        got_err[k]  = res_err;
        k++;
      end
      tick();
      budget++;
    end
    res_ready = 1'b0;
    check("bp_result_count", k, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < k) begin
        check($sformatf("bp_data%0d", i), got_data[i], exp_data[i]);
        check($sformatf("bp_err%0d", i),  got_err[i], 0);
      end
    end
    tick();
    check("bp_idle_busy",  busy, 0);
    check("bp_idle_ready", cmd_ready, 1);

    // Reset in the middle of WAIT with a second command queued
    send(3'd0, 16'd1, 16'd1);
    send(3'd2, 16'd2, 16'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",   res_valid, 0);
    check("mid_rst_busy",    busy, 0);
    check("mid_rst_ready",   cmd_ready, 1);
    check("mid_rst_calc_op", calc_op, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", res_valid, 0);
    end
    check("post_rst_busy", busy, 0);

    // Fresh command after the flush still works: 10 % 3 = 1
    send(3'd4, 16'd10, 16'd3);
    tick();
    tick();
    tick();
    check("post_rst_mod_valid", res_valid, 1);
    check("post_rst_mod_data",  res_data, 1);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
